// File: rtl/ps2_keyboard_decoder_if.sv
// Boundary of the PS/2 keyboard decoder: raw pin inputs and decoded key outputs.
// The decoder takes the master side; whatever drives the pins and reads results takes the slave side.
interface ps2_keyboard_decoder_if;
    logic       ps2_clk;
    logic       ps2_data;
    logic [5:0] acoes;
    logic [7:0] scan_code;
    logic       scan_valid;
    logic       frame_err;

    modport master (input ps2_clk, ps2_data, output acoes, scan_code, scan_valid, frame_err);
    modport slave  (output ps2_clk, ps2_data, input acoes, scan_code, scan_valid, frame_err);
endinterface

// File: rtl/ps2_keyboard_decoder.sv
// PS/2 set-2 keyboard front-end: pin sync, clock deglitch, 11-bit deframing and
// make/break/extended decode into a held-key bitmap.
module ps2_keyboard_decoder #(
    parameter int FILTER_LEN     = 8,
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic                   clock,
    input  logic                   reset,
    ps2_keyboard_decoder_if.master bus
);
    localparam int FW = $clog2(FILTER_LEN + 1);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

    logic [1:0]    clk_sync_q, data_sync_q;
    logic          clk_filt_q, clk_filt_d, clk_prev_q;
    logic [FW-1:0] filt_cnt_q, filt_cnt_d;
    logic          fall;
    logic          data_bit;

    state_t        state_q, state_d;
    logic [2:0]    bit_cnt_q, bit_cnt_d;
    logic [7:0]    shift_q, shift_d;
    logic          parity_q, parity_d;
    logic [TW-1:0] to_cnt_q, to_cnt_d;
    logic          ext_q, ext_d, brk_q, brk_d;
    logic [5:0]    acoes_q, acoes_d;
    logic [7:0]    scan_code_q, scan_code_d;
    logic          scan_valid_q, scan_valid_d;
    logic          frame_err_q, frame_err_d;
    logic [5:0]    key_hit;

    function automatic logic [5:0] key_mask(input logic ext, input logic [7:0] code);
        case ({ext, code})
            9'h175:  key_mask = 6'b000001;
            9'h172:  key_mask = 6'b000010;
            9'h16B:  key_mask = 6'b000100;
            9'h174:  key_mask = 6'b001000;
            9'h029:  key_mask = 6'b010000;
            9'h05A:  key_mask = 6'b100000;
            default: key_mask = 6'b000000;
        endcase
    endfunction

    // Both pins idle high, so the synchronizers and the filtered clock reset to 1.
    // NOTE: non-blocking assignments in clocked blocks so every register samples pre-edge values.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            clk_sync_q  <= 2'b11;
            data_sync_q <= 2'b11;
            clk_filt_q  <= 1'b1;
            clk_prev_q  <= 1'b1;
            filt_cnt_q  <= '0;
        end else begin
            clk_sync_q  <= {clk_sync_q[0], bus.ps2_clk};
            data_sync_q <= {data_sync_q[0], bus.ps2_data};
            clk_filt_q  <= clk_filt_d;
            clk_prev_q  <= clk_filt_q;
            filt_cnt_q  <= filt_cnt_d;
        end
    end

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        clk_filt_d = clk_filt_q;
        filt_cnt_d = '0;
        if (clk_sync_q[1] != clk_filt_q) begin
            if (filt_cnt_q == FW'(FILTER_LEN - 1)) clk_filt_d = ~clk_filt_q;
            else                                   filt_cnt_d = filt_cnt_q + 1'b1;
        end
    end

    assign fall     = clk_prev_q & ~clk_filt_q;
    assign data_bit = data_sync_q[1];

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            bit_cnt_q    <= '0;
            shift_q      <= '0;
            parity_q     <= 1'b0;
            to_cnt_q     <= '0;
            ext_q        <= 1'b0;
            brk_q        <= 1'b0;
            acoes_q      <= '0;
            scan_code_q  <= '0;
            scan_valid_q <= 1'b0;
            frame_err_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            bit_cnt_q    <= bit_cnt_d;
            shift_q      <= shift_d;
            parity_q     <= parity_d;
            to_cnt_q     <= to_cnt_d;
            ext_q        <= ext_d;
            brk_q        <= brk_d;
            acoes_q      <= acoes_d;
            scan_code_q  <= scan_code_d;
            scan_valid_q <= scan_valid_d;
            frame_err_q  <= frame_err_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        bit_cnt_d    = bit_cnt_q;
        shift_d      = shift_q;
        parity_d     = parity_q;
        to_cnt_d     = to_cnt_q;
        ext_d        = ext_q;
        brk_d        = brk_q;
        acoes_d      = acoes_q;
        scan_code_d  = scan_code_q;
        scan_valid_d = 1'b0;
        frame_err_d  = 1'b0;
        key_hit      = key_mask(ext_q, shift_q);

        if (fall) begin
            to_cnt_d = '0;
            case (state_q)
                IDLE: begin
                    if (!data_bit) begin
                        state_d   = DATA;
                        bit_cnt_d = '0;
                    end
                end
                DATA: begin
                    shift_d   = {data_bit, shift_q[7:1]};
                    bit_cnt_d = bit_cnt_q + 1'b1;
                    if (bit_cnt_q == 3'd7) state_d = PARITY;
                end
                PARITY: begin
                    parity_d = data_bit;
                    state_d  = STOP;
                end
                STOP: begin
                    state_d = IDLE;
                    if (data_bit && ^{shift_q, parity_q}) begin
                        scan_valid_d = 1'b1;
                        scan_code_d  = shift_q;
                        // Prefixes latch flags; keyboard status replies leave them untouched.
                        if (shift_q == 8'hE0)      ext_d = 1'b1;
                        else if (shift_q == 8'hF0) brk_d = 1'b1;
                        else if (shift_q != 8'hAA && shift_q != 8'hFA) begin
                            acoes_d = brk_q ? (acoes_q & ~key_hit) : (acoes_q | key_hit);
                            ext_d   = 1'b0;
                            brk_d   = 1'b0;
                        end
                    end else begin
                        frame_err_d = 1'b1;
                    end
                end
                default: state_d = IDLE;
            endcase
        end else if (state_q != IDLE) begin
            if (to_cnt_q == TW'(TIMEOUT_CYCLES - 1)) begin
                frame_err_d = 1'b1;
                state_d     = IDLE;
                to_cnt_d    = '0;
            end else begin
                to_cnt_d = to_cnt_q + 1'b1;
            end
        end
    end

    assign bus.acoes      = acoes_q;
    assign bus.scan_code  = scan_code_q;
    assign bus.scan_valid = scan_valid_q;
    assign bus.frame_err  = frame_err_q;
endmodule

// File: tb/tb_ps2_keyboard_decoder.sv
// Self-checking bench for ps2_keyboard_decoder: directed scenarios plus random
// frames, checked against a table-driven key model.
module tb_ps2_keyboard_decoder;
    localparam int HALF    = 16;
    localparam int TIMEOUT = 50000;

    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    ps2_keyboard_decoder_if bus ();

    ps2_keyboard_decoder #(.FILTER_LEN(8), .TIMEOUT_CYCLES(TIMEOUT)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    int pass_cnt  = 0;
    int total_cnt = 0;

    // Pulse monitor
    int         sv_cnt  = 0;
    int         err_cnt = 0;
    logic [5:0] acoes_at_valid = '0;
    always @(negedge clock) begin
        if (!reset) begin
            if (bus.scan_valid) begin
                sv_cnt++;
                acoes_at_valid = bus.acoes;
            end
            if (bus.frame_err) err_cnt++;
        end
    end

    // Reference model: key table of {ext, code} entries, bit index = table position
    int         keymap [6] = '{'h175, 'h172, 'h16B, 'h174, 'h029, 'h05A};
    logic [5:0] m_acoes = '0;
    logic       m_ext = 1'b0, m_brk = 1'b0;
    logic [7:0] m_code = '0;

    function automatic void model_byte(input logic [7:0] b);
        m_code = b;
        if (b == 8'hE0) m_ext = 1'b1;
        else if (b == 8'hF0) m_brk = 1'b1;
        else if (b != 8'hAA && b != 8'hFA) begin
            for (int k = 0; k < 6; k++)
                if (keymap[k] == ({23'd0, m_ext, b})) m_acoes[k] = !m_brk;
            m_ext = 1'b0;
            m_brk = 1'b0;
        end
    endfunction

    function automatic void model_reset();
        m_acoes = '0;
        m_ext   = 1'b0;
        m_brk   = 1'b0;
        m_code  = '0;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic send_bits(input logic [10:0] bits, input int n);
        for (int i = 0; i < n; i++) begin
            bus.ps2_data = bits[i];
            wait_cycles(HALF);
            bus.ps2_clk = 1'b0;
            wait_cycles(HALF);
            bus.ps2_clk = 1'b1;
        end
        bus.ps2_data = 1'b1;
    endtask

    task automatic frame_and_check(input string tag, input logic [7:0] b,
                                   input logic par_flip, input logic stop);
        int   sv0, e0;
        logic good;
        sv0  = sv_cnt;
        e0   = err_cnt;
        good = !par_flip && stop;
        send_bits({stop, (~^b) ^ par_flip, b, 1'b0}, 11);
        wait_cycles(40);
        if (good) model_byte(b);
        check({tag, ".valid"}, sv_cnt - sv0, {31'd0, good});
        check({tag, ".err"}, err_cnt - e0, {31'd0, !good});
        check({tag, ".code"}, bus.scan_code, m_code);
        check({tag, ".acoes"}, bus.acoes, m_acoes);
        if (good) check({tag, ".acoes_at_valid"}, acoes_at_valid, m_acoes);
    endtask

    initial begin
        logic [7:0] pool [10];
        logic [7:0] b;
        int         sv0, e0, r;
        pool = '{8'hE0, 8'hF0, 8'h75, 8'h72, 8'h6B, 8'h74, 8'h29, 8'h5A, 8'hAA, 8'hFA};

        bus.ps2_clk  = 1'b1;
        bus.ps2_data = 1'b1;
        wait_cycles(3);
        check("rst.acoes", bus.acoes, 6'd0);
        check("rst.code", bus.scan_code, 8'd0);
        check("rst.valid", bus.scan_valid, 1'b0);
        check("rst.err", bus.frame_err, 1'b0);
        reset = 1'b0;
        wait_cycles(5);

        // 1: single make code for space
        frame_and_check("t1_29", 8'h29, 1'b0, 1'b1);
        check("t1.acoes_exact", bus.acoes, 6'b010000);

        // 2: extended make, then extended break, of up
        frame_and_check("t2_E0", 8'hE0, 1'b0, 1'b1);
        frame_and_check("t2_75", 8'h75, 1'b0, 1'b1);
        check("t2.up_set", bus.acoes, 6'b010001);
        frame_and_check("t2_E0b", 8'hE0, 1'b0, 1'b1);
        frame_and_check("t2_F0", 8'hF0, 1'b0, 1'b1);
        frame_and_check("t2_75b", 8'h75, 1'b0, 1'b1);
        check("t2.up_clr", bus.acoes, 6'b010000);

        // 3: bad parity is rejected
        frame_and_check("t3_badpar", 8'h5A, 1'b1, 1'b1);

        // 4: partial frame stalls into a timeout, then a clean frame
        e0  = err_cnt;
        sv0 = sv_cnt;
        send_bits({3'b111, 8'h5A}, 5);
        wait_cycles(TIMEOUT + 200);
        check("t4.timeout_err", err_cnt - e0, 1);
        check("t4.no_valid", sv_cnt - sv0, 0);
        frame_and_check("t4_5A", 8'h5A, 1'b0, 1'b1);
        check("t4.enter", bus.acoes[5], 1'b1);

        // 5: short clock glitch while idle
        e0  = err_cnt;
        sv0 = sv_cnt;
        bus.ps2_clk = 1'b0;
        wait_cycles(3);
        bus.ps2_clk = 1'b1;
        wait_cycles(30);
        check("t5.glitch_err", err_cnt - e0, 0);
        check("t5.glitch_valid", sv_cnt - sv0, 0);
        frame_and_check("t5_29", 8'h29, 1'b0, 1'b1);
        check("t5.space", bus.acoes[4], 1'b1);

        // 6: reset in the middle of a frame
        frame_and_check("t6_E0", 8'hE0, 1'b0, 1'b1);
        frame_and_check("t6_6B", 8'h6B, 1'b0, 1'b1);
        frame_and_check("t6_29", 8'h29, 1'b0, 1'b1);
        send_bits({3'b111, 8'h5A}, 5);
        reset = 1'b1;
        model_reset();
        #1;
        check("t6.acoes_in_rst", bus.acoes, 6'd0);
        wait_cycles(4);
        reset = 1'b0;
        wait_cycles(5);
        check("t6.code_after_rst", bus.scan_code, 8'd0);
        frame_and_check("t6_5A", 8'h5A, 1'b0, 1'b1);
        check("t6.acoes_exact", bus.acoes, 6'b100000);

        // Random frames drawn mostly from the key/prefix vocabulary
        for (int n = 0; n < 24; n++) begin
            r = $urandom_range(0, 11);
            if (r >= 10) b = 8'($urandom);
            else         b = pool[r];
            r = $urandom_range(0, 7);
            frame_and_check($sformatf("rnd%0d", n), b, r == 0, r != 1);
        end

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
